// File: rtl/fma_pkg.sv
// Shared definitions for the FMA datapath: rounding-mode encoding and
// half-precision default format parameters.
package fma_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RZ  = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RNA = 3'd4
  } rm_t;

  localparam int FMA_NF   = 10;
  localparam int FMA_NM   = 36;
  localparam int FMA_EW   = 7;
  localparam int FMA_EMAX = 31;

  // Map a raw 3-bit mode code to rm_t; unused codes 5..7 behave as RNE.
  function automatic rm_t rm_decode(input logic [2:0] code);
    rm_t rm;
    case (code)
      3'd1:    rm = RM_RZ;
      3'd2:    rm = RM_RDN;
      3'd3:    rm = RM_RUP;
      3'd4:    rm = RM_RNA;
      default: rm = RM_RNE;
    endcase
    return rm;
  endfunction

endpackage

// File: rtl/round_decide.sv
// Combinational rounding decision: whether to increment the fraction and
// whether an overflow saturates to infinity (1) or to max finite (0).
module round_decide
  import fma_pkg::*;
(
  input  logic [2:0] rm_i,
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       guard_i,
  input  logic       sticky_i,
  output logic       incr_o,
  output logic       ovf_inf_o
);

  rm_t rm_s;
  assign rm_s = rm_decode(rm_i);

  // Per-mode increment and overflow-result selection
  always_comb begin
    incr_o    = 1'b0;
    ovf_inf_o = 1'b1;
    case (rm_s)
      RM_RZ: begin
        incr_o    = 1'b0;
        ovf_inf_o = 1'b0;
      end
      RM_RDN: begin
        incr_o    = sign_i & (guard_i | sticky_i);
        ovf_inf_o = sign_i;
      end
      RM_RUP: begin
        incr_o    = ~sign_i & (guard_i | sticky_i);
        ovf_inf_o = ~sign_i;
      end
      RM_RNA: begin
        incr_o    = guard_i;
        ovf_inf_o = 1'b1;
      end
      default: begin
        incr_o    = guard_i & (lsb_i | sticky_i);
        ovf_inf_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/round_pipe.sv
// Two-stage valid/ready floating-point rounder.
// Stage 1 extracts L/G/S and decides the increment; stage 2 adds it,
// propagates carry into the exponent and saturates on overflow.
// Optional feature macro: ROUND_FLAGS_EN adds out_flags = {overflow, inexact}.
module round_pipe
  import fma_pkg::*;
#(
  parameter int NF   = FMA_NF,
  parameter int NM   = FMA_NM,
  parameter int EW   = FMA_EW,
  parameter int EMAX = FMA_EMAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [NM-1:0] in_mnorm,
  input  logic [EW-1:0] in_exp,
  input  logic [2:0]    in_rm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [NF-1:0] out_frac,
  output logic [EW-1:0] out_exp
`ifdef ROUND_FLAGS_EN
  ,
  output logic [1:0]    out_flags
`endif
);

  localparam int            EMAX_M1_INT = EMAX - 1;
  localparam logic [EW:0]   EMAX_W      = EMAX[EW:0];
  localparam logic [EW-1:0] EMAX_E      = EMAX[EW-1:0];
  localparam logic [EW-1:0] EMAX_M1     = EMAX_M1_INT[EW-1:0];

  // Global advance: whole pipe moves unless the output is held.
  logic adv_s;
  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  // Stage 1 field extraction and decision
  logic [NF-1:0] frac_s;
  logic          guard_s;
  logic          sticky_s;
  logic          incr_s;
  logic          inf_sel_s;

  assign frac_s   = in_mnorm[NM-2 -: NF];
  assign guard_s  = in_mnorm[NM-2-NF];
  assign sticky_s = |in_mnorm[NM-3-NF:0];

  round_decide u_decide (
    .rm_i      (in_rm),
    .sign_i    (in_sign),
    .lsb_i     (frac_s[0]),
    .guard_i   (guard_s),
    .sticky_i  (sticky_s),
    .incr_o    (incr_s),
    .ovf_inf_o (inf_sel_s)
  );

  // Stage 1 registers
  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_q,  s1_sign_d;
  logic [NF-1:0] s1_frac_q,  s1_frac_d;
  logic [EW-1:0] s1_exp_q,   s1_exp_d;
  logic          s1_incr_q,  s1_incr_d;
  logic          s1_inf_q,   s1_inf_d;
`ifdef ROUND_FLAGS_EN
  logic          s1_inx_q,   s1_inx_d;
`endif

  // Stage 2 (output) registers
  logic          s2_valid_q, s2_valid_d;
  logic          s2_sign_q,  s2_sign_d;
  logic [NF-1:0] s2_frac_q,  s2_frac_d;
  logic [EW-1:0] s2_exp_q,   s2_exp_d;
`ifdef ROUND_FLAGS_EN
  logic [1:0]    s2_flags_q, s2_flags_d;
`endif

  // Stage 1 next state: capture the input slot (bubble or beat) on advance
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_frac_d  = s1_frac_q;
    s1_exp_d   = s1_exp_q;
    s1_incr_d  = s1_incr_q;
    s1_inf_d   = s1_inf_q;
`ifdef ROUND_FLAGS_EN
    s1_inx_d   = s1_inx_q;
`endif
    if (adv_s) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in_sign;
      s1_frac_d  = frac_s;
      s1_exp_d   = in_exp;
      s1_incr_d  = incr_s;
      s1_inf_d   = inf_sel_s;
`ifdef ROUND_FLAGS_EN
      s1_inx_d   = guard_s | sticky_s;
`endif
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 datapath: increment, carry into exponent, overflow saturation
  logic [NF:0]   sum_s;
  logic [EW:0]   exp_wide_s;
  logic          ovf_s;
  logic [NF-1:0] rnd_frac_s;
  logic [EW-1:0] rnd_exp_s;

  assign sum_s      = {1'b0, s1_frac_q} + {{NF{1'b0}}, s1_incr_q};
  assign exp_wide_s = {1'b0, s1_exp_q} + {{EW{1'b0}}, sum_s[NF]};
  assign ovf_s      = (exp_wide_s >= EMAX_W);

  // Select rounded result or the mode-dependent saturation value
  always_comb begin
    rnd_frac_s = sum_s[NF-1:0];
    rnd_exp_s  = exp_wide_s[EW-1:0];
    if (ovf_s) begin
      if (s1_inf_q) begin
        rnd_frac_s = '0;
        rnd_exp_s  = EMAX_E;
      end else begin
        rnd_frac_s = '1;
        rnd_exp_s  = EMAX_M1;
      end
    end else begin
      rnd_frac_s = sum_s[NF-1:0];
      rnd_exp_s  = exp_wide_s[EW-1:0];
    end
  end

  // Stage 2 next state: capture stage 1 result on advance, else hold
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_frac_d  = s2_frac_q;
    s2_exp_d   = s2_exp_q;
`ifdef ROUND_FLAGS_EN
    s2_flags_d = s2_flags_q;
`endif
    if (adv_s) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_frac_d  = rnd_frac_s;
      s2_exp_d   = rnd_exp_s;
`ifdef ROUND_FLAGS_EN
      s2_flags_d = {ovf_s, s1_inx_q | ovf_s};
`endif
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous reset of valid and data
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_frac_q  <= '0;
      s1_exp_q   <= '0;
      s1_incr_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_frac_q  <= '0;
      s2_exp_q   <= '0;
`ifdef ROUND_FLAGS_EN
      s1_inx_q   <= 1'b0;
      s2_flags_q <= 2'b00;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_frac_q  <= s1_frac_d;
      s1_exp_q   <= s1_exp_d;
      s1_incr_q  <= s1_incr_d;
      s1_inf_q   <= s1_inf_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_frac_q  <= s2_frac_d;
      s2_exp_q   <= s2_exp_d;
`ifdef ROUND_FLAGS_EN
      s1_inx_q   <= s1_inx_d;
      s2_flags_q <= s2_flags_d;
`endif
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_frac  = s2_frac_q;
  assign out_exp   = s2_exp_q;
`ifdef ROUND_FLAGS_EN
  assign out_flags = s2_flags_q;
`endif

endmodule

// File: tb/tb_round_pipe.sv
// Directed self-checking bench for round_pipe (default parameters).
// Build with ROUND_FLAGS_EN to also check out_flags.
module tb_round_pipe;

  localparam int NF = 10;
  localparam int NM = 36;
  localparam int EW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [NM-1:0] in_mnorm;
  logic [EW-1:0] in_exp;
  logic [2:0]    in_rm;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [NF-1:0] out_frac;
  logic [EW-1:0] out_exp;
`ifdef ROUND_FLAGS_EN
  logic [1:0]    out_flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  round_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mnorm  (in_mnorm),
    .in_exp    (in_exp),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_frac  (out_frac),
    .out_exp   (out_exp)
`ifdef ROUND_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NM-1:0] mk_mnorm(input logic [NF-1:0] frac, input logic g, input logic s);
    logic [NM-1:0] m;
    m              = '0;
    m[NM-1]        = 1'b1;
    m[NM-2 -: NF]  = frac;
    m[NM-2-NF]     = g;
    m[0]           = s;
    return m;
  endfunction

  function automatic logic [NF-1:0] bp_frac(input int i);
    return NF'(i * 37 + 5);
  endfunction

  function automatic logic [EW-1:0] bp_exp(input int i);
    return EW'(i + 3);
  endfunction

  // One isolated beat with out_ready high; checks latency and result.
  task automatic run_one(input string tag, input logic sign, input logic [2:0] rm,
                         input logic [NF-1:0] frac, input logic g, input logic s,
                         input logic [EW-1:0] e, input logic [NF-1:0] efrac,
                         input logic [EW-1:0] eexp, input logic [1:0] eflags);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sign   = sign;
    in_rm     = rm;
    in_mnorm  = mk_mnorm(frac, g, s);
    in_exp    = e;
    #1;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    #1;
    check_eq({tag, "_valid_c1"}, 32'(out_valid), 32'd0);
    tick;
    #1;
    check_eq({tag, "_valid_c2"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_frac"}, 32'(out_frac), 32'(efrac));
    check_eq({tag, "_exp"},  32'(out_exp),  32'(eexp));
    check_eq({tag, "_sign"}, 32'(out_sign), 32'(sign));
`ifdef ROUND_FLAGS_EN
    check_eq({tag, "_flags"}, 32'(out_flags), 32'(eflags));
`endif
    tick;
  endtask

  initial begin
    int            sent;
    int            rcvd;
    logic          stalled;
    logic          h_sign;
    logic [NF-1:0] h_frac;
    logic [EW-1:0] h_exp;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_mnorm  = '0;
    in_exp    = '0;
    in_rm     = 3'd0;
    out_ready = 1'b0;
    tick;
    tick;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_frac",  32'(out_frac),  32'd0);
    check_eq("rst_out_exp",   32'(out_exp),   32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    tick;

    //        tag         sign  rm    frac     g     s     exp     efrac    eexp    flags
    run_one("rne_even",   1'b0, 3'd0, 10'h000, 1'b1, 1'b0, 7'd15,  10'h000, 7'd15,  2'b01);
    run_one("rne_odd",    1'b0, 3'd0, 10'h001, 1'b1, 1'b0, 7'd15,  10'h002, 7'd15,  2'b01);
    run_one("rup_carry",  1'b0, 3'd3, 10'h3FF, 1'b1, 1'b1, 7'd20,  10'h000, 7'd21,  2'b01);
    run_one("ovf_rne",    1'b0, 3'd0, 10'h3FF, 1'b1, 1'b0, 7'd30,  10'h000, 7'd31,  2'b11);
    run_one("ovf_rz",     1'b0, 3'd1, 10'h3FF, 1'b1, 1'b0, 7'd30,  10'h3FF, 7'd30,  2'b01);
    run_one("ovf_rdn_p",  1'b0, 3'd2, 10'h3FF, 1'b1, 1'b1, 7'd30,  10'h3FF, 7'd30,  2'b01);
    run_one("ovf_rdn_n",  1'b1, 3'd2, 10'h3FF, 1'b1, 1'b0, 7'd30,  10'h000, 7'd31,  2'b11);
    run_one("ovf_rup_n",  1'b1, 3'd3, 10'h155, 1'b1, 1'b0, 7'd31,  10'h3FF, 7'd30,  2'b11);
    run_one("exact",      1'b0, 3'd0, 10'h123, 1'b0, 1'b0, 7'd10,  10'h123, 7'd10,  2'b00);
    run_one("rna_tie",    1'b1, 3'd4, 10'h100, 1'b1, 1'b0, 7'd12,  10'h101, 7'd12,  2'b01);
    run_one("rm5_even",   1'b0, 3'd5, 10'h002, 1'b1, 1'b0, 7'd9,   10'h002, 7'd9,   2'b01);
    run_one("rm6_odd",    1'b0, 3'd6, 10'h003, 1'b1, 1'b0, 7'd9,   10'h004, 7'd9,   2'b01);
    run_one("rup_sticky", 1'b0, 3'd3, 10'h010, 1'b0, 1'b1, 7'd5,   10'h011, 7'd5,   2'b01);
    run_one("exp_top",    1'b0, 3'd3, 10'h3FF, 1'b1, 1'b1, 7'd127, 10'h000, 7'd31,  2'b11);
    tick;

    // Backpressure: 6 back-to-back beats, out_ready pattern 1,0,0,1 repeating.
    sent    = 0;
    rcvd    = 0;
    stalled = 1'b0;
    h_sign  = 1'b0;
    h_frac  = '0;
    h_exp   = '0;
    for (int c = 0; c < 60 && rcvd < 6; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in_sign  = sent[0];
        in_rm    = 3'd1;
        in_mnorm = mk_mnorm(bp_frac(sent), 1'b0, 1'b0);
        in_exp   = bp_exp(sent);
      end
      #1;
      if (stalled) begin
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_frac",  32'(out_frac),  32'(h_frac));
        check_eq("bp_hold_exp",   32'(out_exp),   32'(h_exp));
        check_eq("bp_hold_sign",  32'(out_sign),  32'(h_sign));
      end
      if (out_valid && !out_ready) begin
        check_eq("bp_in_ready_stall", 32'(in_ready), 32'd0);
        stalled = 1'b1;
        h_sign  = out_sign;
        h_frac  = out_frac;
        h_exp   = out_exp;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        check_eq("bp_frac", 32'(out_frac), 32'(bp_frac(rcvd)));
        check_eq("bp_exp",  32'(out_exp),  32'(bp_exp(rcvd)));
        check_eq("bp_sign", 32'(out_sign), 32'(rcvd[0]));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    check_eq("bp_count", 32'(rcvd), 32'd6);

    // Reset mid-flight with two beats inside the pipe.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick;
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_rm    = 3'd1;
    in_mnorm = mk_mnorm(10'h2AA, 1'b0, 1'b0);
    in_exp   = 7'd17;
    tick;
    in_mnorm = mk_mnorm(10'h155, 1'b0, 1'b0);
    in_exp   = 7'd18;
    tick;
    in_valid = 1'b0;
    #1;
    check_eq("mid_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_frac",  32'(out_frac),  32'd0);
    check_eq("mid_rst_sign",  32'(out_sign),  32'd0);
    reset = 1'b0;
    #1;
    check_eq("mid_in_ready", 32'(in_ready), 32'd1);
    tick;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_sign   = 1'b0;
    in_rm     = 3'd0;
    in_mnorm  = mk_mnorm(10'h0F0, 1'b1, 1'b1);
    in_exp    = 7'd22;
    tick;
    in_valid = 1'b0;
    #1;
    check_eq("fresh_valid_c1", 32'(out_valid), 32'd0);
    tick;
    #1;
    check_eq("fresh_valid_c2", 32'(out_valid), 32'd1);
    check_eq("fresh_frac",     32'(out_frac),  32'h0F1);
    check_eq("fresh_exp",      32'(out_exp),   32'd22);
    tick;
    check_eq("fresh_drained", 32'(out_valid), 32'd0);
    tick;
    check_eq("no_stale_beat", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
